sum_series_processor: RTL and testbench



---
 rtl/sum_series_processor.sv | 142 ++++++++++++++
 tb/tb_sum_series_processor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sum_series_processor.sv
// rtl/sum_series_processor.sv - start/done arithmetic series accumulator
//
// Purpose: on an accepted start, sums the series 1..n (mode 0/3), the odd
// terms 1,3,5..<=n (mode 1) or the even terms 2,4,6..<=n (mode 2). The sum
// wraps modulo 2^DATA_W and a sticky per-run overflow flag is reported
// alongside the result.
//
// Ports:
//   clk      in   1       system clock, rising edge
//   reset    in   1       synchronous, active-high
//   start    in   1       run request, accepted only when idle
//   n        in   N_W     inclusive series bound, captured on accept
//   mode     in   2       term selection, captured on accept
//   busy     out  1       high whenever a run is in progress
//   done     out  1       one-cycle pulse, outPort/overflow valid
//   overflow out  1       any add of the last run exceeded 2^DATA_W-1
//   outPort  out  DATA_W  result of the last completed run

module sum_series_processor #(
   parameter int DATA_W = 8,
   parameter int N_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [N_W-1:0]    n,
   input  logic [1:0]        mode,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [DATA_W-1:0] outPort
);

   // idx carries two spare bits so idx + 2 cannot wrap even at n = 2^N_W-1.
   localparam int IW    = N_W + 2;
   // The adder is wide enough to hold acc + idx without loss.
   localparam int SUM_W = ((DATA_W > IW) ? DATA_W : IW) + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_ADD   = 3'd3;
   localparam logic [2:0] S_INC   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [N_W-1:0]    n_q, n_d;
   logic [1:0]        mode_q, mode_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              ovf_run_q, ovf_run_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              overflow_q, overflow_d;

   logic [SUM_W-1:0]  sum_full;
   logic              two_step;

   assign sum_full = SUM_W'(acc_q) + SUM_W'(idx_q);
   assign two_step = (mode_q == 2'd1) || (mode_q == 2'd2);

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      mode_d     = mode_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      ovf_run_d  = ovf_run_q;
      out_d      = out_q;
      overflow_d = overflow_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d     = n;
               mode_d  = mode;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            idx_d     = (mode_q == 2'd2) ? IW'(2) : IW'(1);
            acc_d     = '0;
            ovf_run_d = 1'b0;
            state_d   = S_CHECK;
         end
         S_CHECK: begin
            if (idx_q <= {2'b00, n_q}) begin
               state_d = S_ADD;
            end else begin
               out_d      = acc_q;
               overflow_d = ovf_run_q;
               state_d    = S_DONE;
            end
         end
         S_ADD: begin
            acc_d = sum_full[DATA_W-1:0];
            // Any bit above DATA_W means the true sum no longer fits; this
            // also covers idx itself being >= 2^DATA_W.
            if (|sum_full[SUM_W-1:DATA_W]) begin
               ovf_run_d = 1'b1;
            end
            state_d = S_INC;
         end
         S_INC: begin
            idx_d   = idx_q + (two_step ? IW'(2) : IW'(1));
            state_d = S_CHECK;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         mode_q     <= '0;
         idx_q      <= '0;
         acc_q      <= '0;
         ovf_run_q  <= 1'b0;
         out_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         mode_q     <= mode_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         ovf_run_q  <= ovf_run_d;
         out_q      <= out_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign overflow = overflow_q;
   assign outPort  = out_q;

endmodule

// File: tb/tb_sum_series_processor.sv
// tb/tb_sum_series_processor.sv - directed bench for sum_series_processor

module tb_sum_series_processor;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] n;
   logic [1:0] mode;
   logic       busy;
   logic       done;
   logic       overflow;
   logic [7:0] outPort;

   int checks   = 0;
   int failures = 0;
   int edges    = 0;
   int done_cnt;
   int t_done;

   sum_series_processor #(.DATA_W(8), .N_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .n        (n),
      .mode     (mode),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .outPort  (outPort)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Waits for done with a bound; returns the edge index (from E) it was seen at.
   task automatic wait_done(input string tag, output int at);
      int guard;
      guard = 0;
      while (done !== 1'b1 && guard < 3000) begin
         tick();
         guard++;
      end
      if (done !== 1'b1) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
         at = -1;
      end else begin
         at = edges;
      end
   endtask

   task automatic run(input string tag, input logic [7:0] nv, input logic [1:0] mv,
                      input int exp_out, input int exp_ovf, input int exp_lat);
      int at;
      n     = nv;
      mode  = mv;
      start = 1'b1;
      tick();
      edges = 0;
      start = 1'b0;
      chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
      wait_done(tag, at);
      chk({tag, "_latency"}, 32'(at), 32'(exp_lat));
      chk({tag, "_out"}, 32'(outPort), 32'(exp_out));
      chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
      tick();
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      n     = '0;
      mode  = '0;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_out", 32'(outPort), 32'd0);
      reset = 1'b0;
      tick();

      run("n10_m0", 8'd10, 2'd0, 55, 0, 32);
      run("n10_m1", 8'd10, 2'd1, 25, 0, 17);
      run("n10_m2", 8'd10, 2'd2, 30, 0, 17);
      run("n10_m3", 8'd10, 2'd3, 55, 0, 32);
      run("n0_m0", 8'd0, 2'd0, 0, 0, 2);
      run("n1_m2", 8'd1, 2'd2, 0, 0, 2);
      run("n30_m0", 8'd30, 2'd0, 209, 1, 92);
      run("n4_m0", 8'd4, 2'd0, 10, 0, 14);
      // 255*256/2 = 32640 -> 128 mod 256; 128 odd terms sum to 16384 -> 0.
      run("n255_m0", 8'd255, 2'd0, 128, 1, 767);
      run("n255_m1", 8'd255, 2'd1, 0, 1, 386);

      // Inputs changed and start pulsed mid-run must not disturb the run.
      n     = 8'd10;
      mode  = 2'd0;
      start = 1'b1;
      tick();
      edges = 0;
      start = 1'b0;
      repeat (4) tick();
      n    = 8'd3;
      mode = 2'd2;
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("disturb", t_done);
      chk("disturb_latency", 32'(t_done), 32'd32);
      chk("disturb_out", 32'(outPort), 32'd55);
      chk("disturb_ovf", 32'(overflow), 32'd0);
      tick();
      chk("disturb_idle", 32'(busy), 32'd0);
      tick();
      chk("disturb_no_requeue", 32'(busy), 32'd0);

      // Reset mid-run discards the run and clears the outputs.
      run("pre_rst", 8'd30, 2'd0, 209, 1, 92);
      n     = 8'd10;
      mode  = 2'd0;
      start = 1'b1;
      tick();
      edges = 0;
      start = 1'b0;
      repeat (11) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_ovf", 32'(overflow), 32'd0);
      chk("midrst_out", 32'(outPort), 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) done_cnt++;
      end
      chk("midrst_no_done", 32'(done_cnt), 32'd0);
      run("post_rst", 8'd4, 2'd0, 10, 0, 14);

      // start held high: back-to-back runs, done every 13 cycles.
      n     = 8'd3;
      mode  = 2'd0;
      start = 1'b1;
      tick();
      edges = 0;
      wait_done("hold1", t_done);
      chk("hold1_latency", 32'(t_done), 32'd11);
      chk("hold1_out", 32'(outPort), 32'd6);
      tick();
      wait_done("hold2", t_done);
      chk("hold2_latency", 32'(t_done), 32'd24);
      chk("hold2_out", 32'(outPort), 32'd6);
      tick();
      wait_done("hold3", t_done);
      chk("hold3_latency", 32'(t_done), 32'd37);
      chk("hold3_out", 32'(outPort), 32'd6);
      start = 1'b0;
      repeat (2) tick();
      chk("hold_end_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
